// File: rtl/apb_global_pkg.sv
// Shared definitions for the APB slave memory array: default geometry,
// completer FSM encoding and the slave window base-address helper.
package apb_global_pkg;

  localparam int          SLAVE_DEPTH  = 16;
  localparam logic [31:0] SLAVE_STRIDE = 32'h100;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_slv_state_e;

  // Byte address of window i; callers with a non-default stride pass their own.
  function automatic logic [63:0] slave_base(input int i,
                                             input logic [63:0] stride = 64'(SLAVE_STRIDE));
    return 64'(i) * stride;
  endfunction

endpackage

// File: rtl/apb_multi_slave_mem_if.sv
// APB4 bus bundle shared by the requester (master) and the completer array (slave).
interface apb_multi_slave_mem_if #(
    parameter int NO_OF_SLAVES  = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);

    logic [NO_OF_SLAVES-1:0]   pselx;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_multi_slave_mem_bank.sv
// One strobe-masked word memory with a shared read/write index.
// Reset is synchronous and clears every word.
module apb_slave_mem_bank #(
    parameter  int DEPTH      = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BYTES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      index,
    input  logic [BYTES-1:0]      strb,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage must read as zero after reset, so every word is cleared;
    // this makes it a flop array rather than an inferred RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strb[b]) begin
                    mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer array: NO_OF_SLAVES word memories behind one port, with
// programmable wait states and pslverr on select/alignment/window faults.
// Optional macro APB_SLV_SECURE_CHECK_EN rejects non-secure access to SECURE_MASK slaves.
module apb_multi_slave_mem #(
    parameter int                      NO_OF_SLAVES  = 4,
    parameter int                      ADDRESS_WIDTH = 32,
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      SLAVE_DEPTH   = apb_global_pkg::SLAVE_DEPTH,
    parameter logic [31:0]             SLAVE_STRIDE  = apb_global_pkg::SLAVE_STRIDE,
    parameter int                      WAIT_STATES   = 2,
    parameter logic [NO_OF_SLAVES-1:0] SECURE_MASK   = '0
) (
    input  logic                   pclk,
    input  logic                   preset_n,
    apb_multi_slave_mem_if.slave   bus
);

    import apb_global_pkg::*;

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ALIGN_SH = $clog2(BYTES);
    localparam int IDX_W    = (SLAVE_DEPTH > 1) ? $clog2(SLAVE_DEPTH) : 1;
    localparam int SEL_W    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WIN_BYTES  = ADDRESS_WIDTH'(SLAVE_DEPTH * BYTES);
    localparam logic [3:0]               WS         = 4'(WAIT_STATES);

    apb_slv_state_e          state;
    logic [3:0]              cnt;
    logic                    lat_err;
    logic                    lat_write;
    logic [SEL_W-1:0]        lat_idx;
    logic [IDX_W-1:0]        lat_word;

    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic [SEL_W-1:0]        dec_idx;
    logic [ADDRESS_WIDTH-1:0] dec_base;
    logic [ADDRESS_WIDTH-1:0] dec_off;
    logic [IDX_W-1:0]        dec_word;
    logic                    dec_err;
    logic                    sec_fault;

    logic                    setup;
    logic                    access;
    logic [SEL_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        mem_index;
    logic [DATA_WIDTH-1:0]   bank_rdata [NO_OF_SLAVES];
    logic [DATA_WIDTH-1:0]   sel_rdata;

    assign setup  = (|bus.pselx) && !bus.penable;
    assign access = (|bus.pselx) && bus.penable;

`ifdef APB_SLV_SECURE_CHECK_EN
    assign sec_fault = bus.pprot[1] && SECURE_MASK[dec_idx];
    logic unused_prot;
    assign unused_prot = bus.pprot[0] ^ bus.pprot[2];
`else
    assign sec_fault = 1'b0;
    logic unused_sec;
    assign unused_sec = ^{bus.pprot, SECURE_MASK};
`endif

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (bus.pselx[i]) dec_idx = SEL_W'(i);
        end
        dec_base = ADDRESS_WIDTH'(slave_base(int'(dec_idx), 64'(SLAVE_STRIDE)));
        dec_off  = bus.paddr - dec_base;
        dec_word = IDX_W'(dec_off >> ALIGN_SH);
        dec_err  = !$onehot(bus.pselx)
                || ((bus.paddr & ALIGN_MASK) != '0)
                || (bus.paddr < dec_base)
                || (dec_off >= WIN_BYTES)
                || sec_fault;
    end

    // From IDLE the decode is live (zero-wait reads); afterwards use the latched request.
    assign rd_idx    = (state == IDLE) ? dec_idx  : lat_idx;
    assign mem_index = (state == IDLE) ? dec_word : lat_word;
    assign sel_rdata = bank_rdata[rd_idx];

    for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_bank
        logic we;
        assign we = (state == READY) && access && lat_write && !lat_err
                 && (lat_idx == SEL_W'(g));

        apb_slave_mem_bank #(
            .DEPTH      (SLAVE_DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (pclk),
            .rst_n (preset_n),
            .we    (we),
            .index (mem_index),
            .strb  (bus.pstrb),
            .wdata (bus.pwdata),
            .rdata (bank_rdata[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_word  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (setup) begin
                        lat_err   <= dec_err;
                        lat_write <= bus.pwrite;
                        lat_idx   <= dec_idx;
                        lat_word  <= dec_word;
                        if (WS == 4'd0) begin
                            state     <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            if (dec_err)          prdata_q <= '0;
                            else if (!bus.pwrite) prdata_q <= sel_rdata;
                        end else begin
                            cnt   <= WS;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state     <= READY;
                        cnt       <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= lat_err;
                        if (lat_err)        prdata_q <= '0;
                        else if (!lat_write) prdata_q <= sel_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                READY: begin
                    // Completion and abort both end here; only completion enables the write.
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule
